// File: rtl/cache_refill_unit.sv
// ---------------------------------------------------------------------------
// cache_refill_unit
//   Memory-side refill engine for the instruction cache. On a miss it latches
//   the line-aligned base address, then reads the four words of that line
//   from word-wide instruction memory, one per mem_read/mem_ready handshake,
//   and presents the assembled line on data_line with a one-cycle line_valid.
//
// Ports
//   clock         system clock, all state updates on posedge
//   reset         synchronous, active-high
//   miss_req      miss request level, sampled only while idle
//   miss_address  missed byte address (any alignment)
//   mem_read      read request to instruction memory (high while fetching)
//   mem_address   byte address of the word being read (line base + 4*k)
//   mem_data      read data, valid when mem_ready=1
//   mem_ready     memory has mem_data for the current mem_address
//   data_line     last complete line; word at offset 0 in the top word slot
//   line_valid    one-cycle pulse when data_line holds a freshly fetched line
//   busy          high while fetching or completing; miss_req ignored then
// ---------------------------------------------------------------------------
module cache_refill_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      miss_req,
  input  logic [ADDR_WIDTH-1:0]     miss_address,
  output logic                      mem_read,
  output logic [ADDR_WIDTH-1:0]     mem_address,
  input  logic [WORD_WIDTH-1:0]     mem_data,
  input  logic                      mem_ready,
  output logic [4*WORD_WIDTH-1:0]   data_line,
  output logic                      line_valid,
  output logic                      busy
);

  localparam int WORD_BYTES = WORD_WIDTH / 8;
  localparam int LINE_BYTES = 4 * WORD_BYTES;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [1:0]                k_q, k_d;
  // Only words 0..2 are buffered; word 3 goes straight into data_line so a
  // partially filled line is never visible on the output.
  logic [WORD_WIDTH-1:0]     buf_q [3];
  logic [WORD_WIDTH-1:0]     buf_d [3];
  logic [4*WORD_WIDTH-1:0]   data_line_q, data_line_d;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    k_d         = k_q;
    buf_d       = buf_q;
    data_line_d = data_line_q;
    mem_read    = 1'b0;
    line_valid  = 1'b0;
    busy        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          // Masking with a constant keeps every address bit in use.
          base_d  = miss_address & ~ADDR_WIDTH'(LINE_BYTES - 1);
          k_d     = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_read = 1'b1;
        busy     = 1'b1;
        if (mem_ready) begin
          case (k_q)
            2'd0: buf_d[0] = mem_data;
            2'd1: buf_d[1] = mem_data;
            2'd2: buf_d[2] = mem_data;
            default: begin
              data_line_d = {buf_q[0], buf_q[1], buf_q[2], mem_data};
              state_d     = S_DONE;
            end
          endcase
          if (k_q != 2'd3) begin
            k_d = k_q + 2'd1;
          end
        end
      end

      S_DONE: begin
        line_valid = 1'b1;
        busy       = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Wraps modulo 2^ADDR_WIDTH; k never carries into the base.
  assign mem_address = base_q + (ADDR_WIDTH'(k_q) << WORD_SHIFT);
  assign data_line   = data_line_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      k_q         <= '0;
      buf_q       <= '{default: '0};
      data_line_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      k_q         <= k_d;
      buf_q       <= buf_d;
      data_line_q <= data_line_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_unit.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_unit
//   Randomized scoreboard bench. The driver pushes the expected line (computed
//   from a behavioural memory image) when it issues a miss; a negedge monitor
//   tracks the read sequence and pops/compares on every line_valid. The same
//   negedge process plays instruction memory with configurable wait states.
// ---------------------------------------------------------------------------
module tb_cache_refill_unit;

  logic         clock = 1'b0;
  logic         reset;
  logic         miss_req;
  logic [31:0]  miss_address;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [31:0]  mem_data;
  logic         mem_ready;
  logic [127:0] data_line;
  logic         line_valid;
  logic         busy;

  always #5 clock = ~clock;

  cache_refill_unit #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .miss_req     (miss_req),
    .miss_address (miss_address),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .data_line    (data_line),
    .line_valid   (line_valid),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory image: byte pattern b,b+1,b+2,b+3 of the low address byte, with the
  // upper address bits folded in so every line in the space is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b, b + 8'd1, b + 8'd2, b + 8'd3} ^ {a[31:8], 8'h00};
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr - (addr % 16);
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] addr);
    logic [31:0] b;
    b = line_base(addr);
    return {mem_word(b), mem_word(b + 4), mem_word(b + 8), mem_word(b + 12)};
  endfunction

  typedef struct {
    logic [127:0] line;
    logic [31:0]  base;
    int           acc;
  } exp_t;

  exp_t exp_q[$];

  int cyc = 0;
  always @(posedge clock) cyc++;

  int           wait_mode  = 0;  // 0: no waits, 1: 3 waits per word, 2: random
  int           wait_left  = 0;
  int           waits_seen = 0;
  int           widx       = 0;  // words handed over in the current refill
  logic         last_read  = 1'b0;
  logic         last_ready = 1'b0;
  logic         last_lv    = 1'b0;
  logic [127:0] last_line  = '0;
  bit           flush      = 1'b0;

  function automatic int pick_wait();
    case (wait_mode)
      0:       return 0;
      1:       return 3;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  always @(negedge clock) begin : mon
    exp_t e;
    bit   hs;
    if (flush) begin
      chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_line_valid", {127'd0, line_valid}, 128'd0);
      chk("rst_data_line", data_line, 128'd0);
      chk("rst_mem_address", {96'd0, mem_address}, 128'd0);
      exp_q.delete();
      widx       = 0;
      waits_seen = 0;
      last_line  = '0;
      last_read  = 1'b0;
      last_ready = 1'b0;
      last_lv    = 1'b0;
      flush      = 1'b0;
    end else begin
      hs = last_read && last_ready;
      if (hs) widx++;
      if (mem_read) begin
        if (exp_q.size() == 0) chk("unexpected_mem_read", 128'd1, 128'd0);
        else chk("mem_address", {96'd0, mem_address}, {96'd0, exp_q[0].base + 32'(widx * 4)});
        chk("busy_in_fetch", {127'd0, busy}, 128'd1);
      end
      if (line_valid) begin
        chk("lv_single_cycle", {127'd0, last_lv}, 128'd0);
        chk("lv_busy", {127'd0, busy}, 128'd1);
        chk("lv_no_read", {127'd0, mem_read}, 128'd0);
        if (exp_q.size() == 0) begin
          chk("spurious_line_valid", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data_line", data_line, e.line);
          chk("latency", 128'(cyc - e.acc), 128'(4 + waits_seen));
          chk("words_captured", 128'(widx), 128'd4);
          last_line = e.line;
        end
        widx       = 0;
        waits_seen = 0;
      end else begin
        chk("data_line_stable", data_line, last_line);
      end
      last_lv = line_valid;
    end

    // Instruction memory behaviour for the coming cycle.
    hs = last_read && last_ready;
    if (mem_read) begin
      if (hs) wait_left = pick_wait();
      if (wait_left > 0) begin
        mem_ready = 1'b0;
        mem_data  = $urandom;
        wait_left--;
        waits_seen++;
      end else begin
        mem_ready = 1'b1;
        mem_data  = mem_word(mem_address);
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));  // ignored while not reading
      mem_data  = $urandom;
      wait_left = pick_wait();
    end
    last_read  = mem_read;
    last_ready = mem_ready;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_before_req", {127'd0, busy}, 128'd0);
  endtask

  task automatic issue(input logic [31:0] addr);
    exp_t e;
    e.line = line_of(addr);
    e.base = line_base(addr);
    e.acc  = cyc + 1;
    exp_q.push_back(e);
    miss_req     = 1'b1;
    miss_address = addr;
    tick();
  endtask

  // Cache-like requester: holds miss_req until line_valid (scrambling the
  // address meanwhile), or in pulse mode re-pulses miss_req with address 64.
  task automatic refill(input logic [31:0] addr, input bit pulse64);
    int n;
    wait_idle();
    issue(addr);
    n = 0;
    while (!line_valid && n < 200) begin
      if (pulse64) begin
        miss_req     = (n == 1);
        miss_address = 32'd64;
      end else begin
        miss_address = $urandom;
      end
      tick();
      n++;
    end
    chk("line_valid_seen", {127'd0, line_valid}, 128'd1);
    miss_req = 1'b0;
  endtask

  task automatic reset_mid_fetch();
    int n;
    wait_idle();
    issue(32'h0000_0100);
    miss_req = 1'b0;
    n = 0;
    while (widx < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("reached_word2", {127'd0, (widx >= 2)}, 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b1;
    chk("rst_mid_busy", {127'd0, busy}, 128'd0);
    chk("rst_mid_read", {127'd0, mem_read}, 128'd0);
    tick();
  endtask

  initial begin
    logic [31:0] addr;
    reset        = 1'b1;
    miss_req     = 1'b0;
    miss_address = '0;
    mem_ready    = 1'b0;
    mem_data     = '0;
    flush        = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    wait_mode = 0; refill(32'd0, 1'b0);
    refill(32'd20, 1'b0);
    wait_mode = 1; refill(32'd0, 1'b0);
    wait_mode = 0; refill(32'd0, 1'b1);
    reset_mid_fetch();
    refill(32'd4, 1'b0);
    refill(32'hFFFF_FFF4, 1'b0);

    wait_mode = 2;
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else addr = $urandom;
      refill(addr, 1'b0);
    end

    tick();
    tick();
    tick();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
